// File: rtl/dvs_aer_rx_fifo.sv
// DVS AER receiver: synchronises the camera's 4-phase REQ/ACK bus, pairs each
// X/polarity word with the latest Y word and its timestamp, and buffers the
// completed events in a show-ahead FIFO with a valid/ready consumer port.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | waiting for synced req; decides Y (settle) or X (capture/stall)
// S_SETTLE  | Y word: count down SETTLE_CYCLES before sampling the bus
// S_STALL   | X word arrived with the FIFO full; ack withheld until space
// S_CAPTURE | one cycle, ack high; aer_s sampled on the exit edge
// S_ACK_WAIT| ack held high until the camera drops req
module dvs_aer_rx_fifo #(
  parameter int AER_BITS      = 10,
  parameter int X_ADDR_BITS   = 9,
  parameter int Y_ADDR_BITS   = 9,
  parameter int TS_BITS       = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 3,
  parameter int FIFO_DEPTH    = 8,
  parameter int STALL_ON_FULL = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [AER_BITS-1:0]           aer,
  input  logic                          xsel,
  input  logic                          req,
  input  logic [TS_BITS-1:0]            timestamp_us,
  output logic                          ack,
  output logic                          event_valid,
  input  logic                          event_ready,
  output logic [X_ADDR_BITS-1:0]        event_x,
  output logic [Y_ADDR_BITS-1:0]        event_y,
  output logic [TS_BITS-1:0]            event_timestamp,
  output logic                          event_polarity,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  // Counter is at least one bit wide so SETTLE_CYCLES of 0 or 1 still elaborates.
  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_STALL,
    S_CAPTURE,
    S_ACK_WAIT
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] req_sync, xsel_sync;
  logic [AER_BITS-1:0]    aer_sync [SYNC_STAGES];
  logic                   req_s, xsel_s;
  logic [AER_BITS-1:0]    aer_s;

  logic [CW-1:0]          settle_cnt;
  logic                   is_x;
  logic                   y_valid;
  logic [Y_ADDR_BITS-1:0] y_reg;
  logic [TS_BITS-1:0]     ts_reg;

  logic [X_ADDR_BITS-1:0] mem_x   [FIFO_DEPTH];
  logic [Y_ADDR_BITS-1:0] mem_y   [FIFO_DEPTH];
  logic [TS_BITS-1:0]     mem_ts  [FIFO_DEPTH];
  logic                   mem_pol [FIFO_DEPTH];
  logic [LW-1:0]          wr_ptr, rd_ptr;

  logic full, pop, push_req, push_ok, drop;

  // Multi-stage synchronisers on every asynchronous camera input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_sync  <= '0;
      xsel_sync <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) aer_sync[i] <= '0;
    end else begin
      req_sync    <= {req_sync[SYNC_STAGES-2:0], req};
      xsel_sync   <= {xsel_sync[SYNC_STAGES-2:0], xsel};
      aer_sync[0] <= aer;
      for (int i = 1; i < SYNC_STAGES; i++) aer_sync[i] <= aer_sync[i-1];
    end
  end

  assign req_s  = req_sync[SYNC_STAGES-1];
  assign xsel_s = xsel_sync[SYNC_STAGES-1];
  assign aer_s  = aer_sync[SYNC_STAGES-1];

  assign fifo_level  = wr_ptr - rd_ptr;
  assign full        = (fifo_level == LW'(FIFO_DEPTH));
  assign event_valid = (fifo_level != '0);
  assign pop         = event_valid & event_ready;
  assign push_req    = (state == S_CAPTURE) & is_x;
  // A push into a full FIFO is still taken when the head leaves on the same edge.
  assign push_ok     = push_req & y_valid & (~full | pop);
  assign drop        = push_req & ~push_ok;

  // Handshake FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode for the REQ/ACK handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_s) begin
          if (!xsel_s)
            state_nxt = (SETTLE_CYCLES == 0) ? S_CAPTURE : S_SETTLE;
          else if ((STALL_ON_FULL != 0) && full)
            state_nxt = S_STALL;
          else
            state_nxt = S_CAPTURE;
        end
      end
      S_SETTLE: begin
        if (!req_s)               state_nxt = S_IDLE;
        else if (settle_cnt <= CW'(1)) state_nxt = S_CAPTURE;
      end
      S_STALL: begin
        if (!req_s)     state_nxt = S_IDLE;
        else if (!full) state_nxt = S_CAPTURE;
      end
      S_CAPTURE:  state_nxt = S_ACK_WAIT;
      S_ACK_WAIT: if (!req_s) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // ack is registered from the next state so it is glitch-free toward the camera.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ack <= 1'b0;
    else     ack <= (state_nxt == S_CAPTURE) || (state_nxt == S_ACK_WAIT);
  end

  // Settle down-counter: loaded on SETTLE entry, terminal count at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      settle_cnt <= '0;
    else if ((state != S_SETTLE) && (state_nxt == S_SETTLE))
      settle_cnt <= CW'(SETTLE_CYCLES);
    else if ((state == S_SETTLE) && (settle_cnt != '0))
      settle_cnt <= settle_cnt - CW'(1);
  end

  // Word-type latch and Y/timestamp capture for pairing with later X words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_x    <= 1'b0;
      y_valid <= 1'b0;
      y_reg   <= '0;
      ts_reg  <= '0;
    end else begin
      if ((state == S_IDLE) && req_s) is_x <= xsel_s;
      if ((state == S_CAPTURE) && !is_x) begin
        y_reg   <= aer_s[Y_ADDR_BITS-1:0];
        ts_reg  <= timestamp_us;
        y_valid <= 1'b1;
      end
    end
  end

  // Event FIFO storage and pointers; head is read combinationally (show-ahead).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_x[i]   <= '0;
        mem_y[i]   <= '0;
        mem_ts[i]  <= '0;
        mem_pol[i] <= 1'b0;
      end
    end else begin
      if (push_ok) begin
        mem_x[wr_ptr[AW-1:0]]   <= aer_s[X_ADDR_BITS:1];
        mem_y[wr_ptr[AW-1:0]]   <= y_reg;
        mem_ts[wr_ptr[AW-1:0]]  <= ts_reg;
        mem_pol[wr_ptr[AW-1:0]] <= aer_s[0];
        wr_ptr <= wr_ptr + LW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + LW'(1);
    end
  end

  assign event_x         = mem_x[rd_ptr[AW-1:0]];
  assign event_y         = mem_y[rd_ptr[AW-1:0]];
  assign event_timestamp = mem_ts[rd_ptr[AW-1:0]];
  assign event_polarity  = mem_pol[rd_ptr[AW-1:0]];

  // Saturating count of refused X words (orphans and overflow drops).
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop_count <= '0;
    else if (drop && (drop_count != 16'hFFFF))
      drop_count <= drop_count + 16'd1;
  end

endmodule

// File: tb/tb_dvs_aer_rx_fifo.sv
// Bench for dvs_aer_rx_fifo: three instances (stall mode, drop mode, long
// settle) each with their own camera/consumer signals, checked against an
// event-list model of the receiver.
module tb_dvs_aer_rx_fifo;

  typedef struct {
    logic [8:0]  x;
    logic [8:0]  y;
    logic [31:0] ts;
    logic        p;
  } ev_t;

  logic        clk;
  logic        rst;
  logic [9:0]  aer_a   [3];
  logic        xsel_a  [3];
  logic        req_a   [3];
  logic [31:0] ts_a    [3];
  logic        ready_a [3];
  logic        ack_a   [3];
  logic        ev_a    [3];
  logic [8:0]  ex_a    [3];
  logic [8:0]  ey_a    [3];
  logic [31:0] et_a    [3];
  logic        ep_a    [3];
  logic [3:0]  lvl_a   [3];
  logic [15:0] dc_a    [3];

  int checks = 0;
  int errors = 0;

  ev_t         exp_q[$];
  bit          m_yv;
  logic [8:0]  m_y;
  logic [31:0] m_ts;
  int          m_drops;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dvs_aer_rx_fifo #(
      .SETTLE_CYCLES((g == 2) ? 5 : 3),
      .STALL_ON_FULL((g == 1) ? 0 : 1)
    ) u_dut (
      .clk             (clk),
      .rst             (rst),
      .aer             (aer_a[g]),
      .xsel            (xsel_a[g]),
      .req             (req_a[g]),
      .timestamp_us    (ts_a[g]),
      .ack             (ack_a[g]),
      .event_valid     (ev_a[g]),
      .event_ready     (ready_a[g]),
      .event_x         (ex_a[g]),
      .event_y         (ey_a[g]),
      .event_timestamp (et_a[g]),
      .event_polarity  (ep_a[g]),
      .fifo_level      (lvl_a[g]),
      .drop_count      (dc_a[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural model: Y words remember (y, ts); X words become events unless
  // orphaned or the (non-draining) FIFO already holds 8 entries.
  function automatic void model_clear();
    exp_q.delete();
    m_yv = 0; m_y = '0; m_ts = '0; m_drops = 0;
  endfunction

  function automatic void model_apply(bit xs, logic [9:0] data, logic [31:0] t);
    ev_t e;
    if (!xs) begin
      m_yv = 1; m_y = data[8:0]; m_ts = t;
    end else if (!m_yv || exp_q.size() >= 8) begin
      if (m_drops < 65535) m_drops++;
    end else begin
      e.x = data[9:1]; e.y = m_y; e.ts = m_ts; e.p = data[0];
      exp_q.push_back(e);
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      aer_a[d] = '0; xsel_a[d] = 1'b0; req_a[d] = 1'b0;
      ts_a[d] = '0; ready_a[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_word(input int d, input bit xs, input logic [9:0] data,
                           input logic [31:0] t);
    int n;
    @(negedge clk);
    aer_a[d] = data; xsel_a[d] = xs; ts_a[d] = t; req_a[d] = 1'b1;
    n = 0;
    while (ack_a[d] !== 1'b1 && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL ack_rise dut%0d: ack=%b required 1 within 60 cycles", d, ack_a[d]);
    end
    req_a[d] = 1'b0;
    n = 0;
    while (ack_a[d] !== 1'b0 && n < 60) begin @(negedge clk); n++; end
    checks++;
    if (n >= 60) begin
      errors++;
      $display("FAIL ack_fall dut%0d: ack=%b required 0 within 60 cycles", d, ack_a[d]);
    end
  endtask

  task automatic hs_measure(input int d, input bit xs, input logic [9:0] data,
                            input logic [31:0] t, output int rise, output int ev_rise,
                            output int fall);
    @(negedge clk);
    aer_a[d] = data; xsel_a[d] = xs; ts_a[d] = t; req_a[d] = 1'b1;
    rise = 0; ev_rise = 0; fall = 0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      if (rise == 0 && ack_a[d] === 1'b1) rise = k;
      if (ev_rise == 0 && ev_a[d] === 1'b1) ev_rise = k;
    end
    @(negedge clk);
    req_a[d] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (ack_a[d] === 1'b0) begin fall = k; break; end
    end
  endtask

  // Pops everything in exp_q with a random ready pattern, comparing each head.
  task automatic drain(input int d, input string tag);
    int cyc;
    bit r;
    ev_t e;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 300) begin
      @(negedge clk);
      r = 1'($urandom_range(0, 1));
      ready_a[d] = r;
      if (r) begin
        e = exp_q[0];
        checks++;
        if ({ev_a[d], ex_a[d], ey_a[d], et_a[d], ep_a[d]} !== {1'b1, e.x, e.y, e.ts, e.p}) begin
          errors++;
          $display("FAIL %s head dut%0d: got v=%b x=%h y=%h ts=%h p=%b required v=1 x=%h y=%h ts=%h p=%b",
                   tag, d, ev_a[d], ex_a[d], ey_a[d], et_a[d], ep_a[d], e.x, e.y, e.ts, e.p);
        end
        void'(exp_q.pop_front());
      end
      cyc++;
    end
    @(negedge clk);
    ready_a[d] = 1'b0;
    checks++;
    if (exp_q.size() != 0 || ev_a[d] !== 1'b0 || lvl_a[d] !== 4'd0) begin
      errors++;
      $display("FAIL %s drained dut%0d: valid=%b level=%0d left=%0d required 0/0/0",
               tag, d, ev_a[d], lvl_a[d], exp_q.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if ({ack_a[d], ev_a[d], lvl_a[d], dc_a[d]} !== '0 ||
          {ex_a[d], ey_a[d], et_a[d], ep_a[d]} !== '0) begin
        errors++;
        $display("FAIL reset dut%0d: ack=%b valid=%b level=%0d drops=%0d x=%h y=%h ts=%h p=%b required all 0",
                 d, ack_a[d], ev_a[d], lvl_a[d], dc_a[d], ex_a[d], ey_a[d], et_a[d], ep_a[d]);
      end
    end
  endtask

  task automatic test_timing();
    int rise, evr, fall;
    do_reset();
    hs_measure(0, 1'b0, 10'h05A, 32'd1000, rise, evr, fall);
    checks++;
    if (rise != 6 || fall != 3 || evr != 0) begin
      errors++;
      $display("FAIL timing_y: ack_rise=%0d ack_fall=%0d valid_rise=%0d required 6/3/0", rise, fall, evr);
    end
    hs_measure(0, 1'b1, 10'h0C7, 32'd2000, rise, evr, fall);
    checks++;
    if (rise != 3 || evr != 4 || fall != 3) begin
      errors++;
      $display("FAIL timing_x: ack_rise=%0d valid_rise=%0d ack_fall=%0d required 3/4/3", rise, evr, fall);
    end
    @(negedge clk);
    checks++;
    if ({ex_a[0], ey_a[0], et_a[0], ep_a[0], lvl_a[0]} !== {9'h063, 9'h05A, 32'd1000, 1'b1, 4'd1}) begin
      errors++;
      $display("FAIL first_event: x=%h y=%h ts=%0d p=%b level=%0d required 063/05a/1000/1/1",
               ex_a[0], ey_a[0], et_a[0], ep_a[0], lvl_a[0]);
    end
  endtask

  task automatic test_orphan();
    do_reset();
    send_word(0, 1'b1, 10'h0C7, 32'd50);
    repeat (3) @(negedge clk);
    checks++;
    if (dc_a[0] !== 16'd1 || ev_a[0] !== 1'b0 || lvl_a[0] !== 4'd0 || ack_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL orphan: drops=%0d valid=%b level=%0d ack=%b required 1/0/0/0",
               dc_a[0], ev_a[0], lvl_a[0], ack_a[0]);
    end
  endtask

  task automatic test_stall_full();
    logic [9:0] w;
    int n;
    do_reset();
    model_clear();
    send_word(0, 1'b0, 10'h011, 32'd500);
    model_apply(1'b0, 10'h011, 32'd500);
    for (int i = 0; i < 8; i++) begin
      w = 10'($urandom);
      send_word(0, 1'b1, w, 32'($urandom));
      model_apply(1'b1, w, 32'd0);
    end
    checks++;
    if (lvl_a[0] !== 4'd8) begin
      errors++;
      $display("FAIL stall_level8: level=%0d required 8", lvl_a[0]);
    end
    w = 10'($urandom);
    @(negedge clk);
    aer_a[0] = w; xsel_a[0] = 1'b1; req_a[0] = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (ack_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL stall_noack: ack=%b required 0 while full", ack_a[0]);
    end
    checks++;
    if (ex_a[0] !== exp_q[0].x || ey_a[0] !== exp_q[0].y) begin
      errors++;
      $display("FAIL stall_head: x=%h y=%h required x=%h y=%h", ex_a[0], ey_a[0], exp_q[0].x, exp_q[0].y);
    end
    ready_a[0] = 1'b1;
    @(negedge clk);
    ready_a[0] = 1'b0;
    void'(exp_q.pop_front());
    n = 0;
    while (ack_a[0] !== 1'b1 && n < 6) begin @(posedge clk); #1; n++; end
    checks++;
    if (ack_a[0] !== 1'b1 || n > 2) begin
      errors++;
      $display("FAIL stall_release: ack=%b after %0d cycles required 1 within 2", ack_a[0], n);
    end
    @(negedge clk);
    req_a[0] = 1'b0;
    n = 0;
    while (ack_a[0] !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    model_apply(1'b1, w, 32'd0);
    checks++;
    if (lvl_a[0] !== 4'd8 || dc_a[0] !== 16'd0 || ack_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL stall_after: level=%0d drops=%0d ack=%b required 8/0/0", lvl_a[0], dc_a[0], ack_a[0]);
    end
    drain(0, "stall");
  endtask

  task automatic test_drop_full();
    logic [9:0] w;
    do_reset();
    model_clear();
    send_word(1, 1'b0, 10'h1E2, 32'd777);
    model_apply(1'b0, 10'h1E2, 32'd777);
    for (int i = 0; i < 9; i++) begin
      w = 10'($urandom);
      send_word(1, 1'b1, w, 32'($urandom));
      model_apply(1'b1, w, 32'd0);
    end
    checks++;
    if (lvl_a[1] !== 4'd8 || dc_a[1] !== 16'(m_drops) || m_drops != 1) begin
      errors++;
      $display("FAIL drop_full: level=%0d drops=%0d required 8/%0d", lvl_a[1], dc_a[1], m_drops);
    end
    drain(1, "drop");
  endtask

  task automatic test_settle_abort();
    int acks;
    logic [9:0] w;
    do_reset();
    model_clear();
    send_word(2, 1'b0, 10'h0A5, 32'd300);
    model_apply(1'b0, 10'h0A5, 32'd300);
    w = 10'($urandom);
    send_word(2, 1'b1, w, 32'd301);
    model_apply(1'b1, w, 32'd301);
    @(negedge clk);
    aer_a[2] = 10'h133; xsel_a[2] = 1'b0; ts_a[2] = 32'd999; req_a[2] = 1'b1;
    acks = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (ack_a[2] !== 1'b0) acks++;
    end
    req_a[2] = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (ack_a[2] !== 1'b0) acks++;
    end
    checks++;
    if (acks != 0) begin
      errors++;
      $display("FAIL settle_abort_ack: ack high for %0d cycles required 0", acks);
    end
    w = 10'($urandom);
    send_word(2, 1'b1, w, 32'd1234);
    model_apply(1'b1, w, 32'd1234);
    drain(2, "settle");
  endtask

  task automatic test_reset_ackwait();
    int n;
    do_reset();
    send_word(0, 1'b0, 10'h022, 32'd10);
    send_word(0, 1'b1, 10'h155, 32'd11);
    @(negedge clk);
    aer_a[0] = 10'h0F0; xsel_a[0] = 1'b1; req_a[0] = 1'b1;
    n = 0;
    while (ack_a[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ack_a[0] !== 1'b0 || ev_a[0] !== 1'b0 || lvl_a[0] !== 4'd0 || n >= 20) begin
      errors++;
      $display("FAIL reset_ackwait: ack=%b valid=%b level=%0d wait=%0d required 0/0/0 (<20)",
               ack_a[0], ev_a[0], lvl_a[0], n);
    end
    req_a[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    int nw;
    bit xs;
    logic [9:0] w;
    logic [31:0] t;
    for (int round = 0; round < 4; round++) begin
      do_reset();
      model_clear();
      nw = $urandom_range(6, 16);
      for (int i = 0; i < nw; i++) begin
        xs = ($urandom_range(0, 9) < 7);
        w = 10'($urandom);
        t = $urandom;
        send_word(1, xs, w, t);
        model_apply(xs, w, t);
      end
      @(negedge clk);
      checks++;
      if (dc_a[1] !== 16'(m_drops) || lvl_a[1] !== 4'(exp_q.size())) begin
        errors++;
        $display("FAIL random_counts r%0d: drops=%0d level=%0d required %0d/%0d",
                 round, dc_a[1], lvl_a[1], m_drops, exp_q.size());
      end
      drain(1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_orphan();
    test_stall_full();
    test_drop_full();
    test_settle_abort();
    test_reset_ackwait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
